// File: rtl/dmem_ctrl_if.sv
// Bundle of the two requester ports and the word-wide memory port of dmem_ctrl.
// slave is the controller's view; master is the requesters-plus-memory view.
interface dmem_ctrl_if;
  logic        req_0;
  logic        we_0;
  logic [10:0] addr_0;
  logic [1:0]  size_0;
  logic        uns_0;
  logic [31:0] wdata_0;
  logic        gnt_0;
  logic        rvalid_0;
  logic [31:0] rdata_0;
  logic        err_0;

  logic        req_1;
  logic        we_1;
  logic [10:0] addr_1;
  logic [1:0]  size_1;
  logic        uns_1;
  logic [31:0] wdata_1;
  logic        gnt_1;
  logic        rvalid_1;
  logic [31:0] rdata_1;
  logic        err_1;

  logic        mem_st_en;
  logic [10:0] mem_addr;
  logic [31:0] mem_st_data;
  logic [31:0] mem_ld_data;

  modport slave (
    input  req_0, we_0, addr_0, size_0, uns_0, wdata_0,
    input  req_1, we_1, addr_1, size_1, uns_1, wdata_1,
    input  mem_ld_data,
    output gnt_0, rvalid_0, rdata_0, err_0,
    output gnt_1, rvalid_1, rdata_1, err_1,
    output mem_st_en, mem_addr, mem_st_data
  );

  modport master (
    output req_0, we_0, addr_0, size_0, uns_0, wdata_0,
    output req_1, we_1, addr_1, size_1, uns_1, wdata_1,
    output mem_ld_data,
    input  gnt_0, rvalid_0, rdata_0, err_0,
    input  gnt_1, rvalid_1, rdata_1, err_1,
    input  mem_st_en, mem_addr, mem_st_data
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Two-port data-memory controller: arbitrates byte/half/word loads and stores
// onto one word-wide memory, using read-modify-write for sub-word stores.
module dmem_ctrl #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  dmem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t state, state_nxt;

  logic        ptr;
  logic        sel_q;
  logic        we_q;
  logic        uns_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [10:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;

  logic        any_req;
  logic        pick;
  logic        grant;
  logic        p_we;
  logic        p_uns;
  logic        p_mis;
  logic [1:0]  p_size;
  logic [10:0] p_addr;
  logic [31:0] p_wdata;

  logic [31:0] merged;
  logic [31:0] ld_val;
  logic [31:0] resp_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        in_resp;
  logic        mem_phase;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = lo[0];
      2'b10:   mis = (lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Requester selection; with a single request the pointer is irrelevant.
  always_comb begin
    any_req = bus.req_0 | bus.req_1;
    if (bus.req_0 && bus.req_1) pick = RR_EN ? ptr : 1'b0;
    else                        pick = bus.req_1;
    if (pick) begin
      p_we    = bus.we_1;
      p_uns   = bus.uns_1;
      p_size  = bus.size_1;
      p_addr  = bus.addr_1;
      p_wdata = bus.wdata_1;
    end else begin
      p_we    = bus.we_0;
      p_uns   = bus.uns_0;
      p_size  = bus.size_0;
      p_addr  = bus.addr_0;
      p_wdata = bus.wdata_0;
    end
    p_mis = misaligned(p_size, p_addr[1:0]);
  end

  assign grant = (state == IDLE) && any_req && !rst_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (p_mis)                         state_nxt = RESP;
          else if (p_we && p_size == 2'b10)  state_nxt = WR;
          else                               state_nxt = RD;
        end
      end
      RD:      state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) ptr <= ~ptr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 11'h000;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
    end else begin
      if (grant) begin
        sel_q   <= pick;
        we_q    <= p_we;
        uns_q   <= p_uns;
        err_q   <= p_mis;
        size_q  <= p_size;
        addr_q  <= p_addr;
        wdata_q <= p_wdata;
      end
      if (state == RD) word_q <= bus.mem_ld_data;
    end
  end

  // Sub-word store: replace only the addressed lane(s) of the captured word.
  always_comb begin
    merged = word_q;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'b00:   merged[7:0]   = wdata_q[7:0];
        2'b01:   merged[15:8]  = wdata_q[7:0];
        2'b10:   merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = word_q[7:0];
      2'b01:   ld_byte = word_q[15:8];
      2'b10:   ld_byte = word_q[23:16];
      default: ld_byte = word_q[31:24];
    endcase
    ld_half = addr_q[1] ? word_q[31:16] : word_q[15:0];
    case (size_q)
      2'b00:   ld_val = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_val = word_q;
    endcase
  end

  assign in_resp   = (state == RESP) && !rst_i;
  assign resp_data = (err_q || we_q) ? 32'h0 : ld_val;
  assign mem_phase = (state == RD) || (state == WR);

  assign bus.gnt_0    = grant && !pick;
  assign bus.gnt_1    = grant && pick;
  assign bus.rvalid_0 = in_resp && !sel_q;
  assign bus.rvalid_1 = in_resp && sel_q;
  assign bus.err_0    = in_resp && !sel_q && err_q;
  assign bus.err_1    = in_resp && sel_q && err_q;
  assign bus.rdata_0  = (in_resp && !sel_q) ? resp_data : 32'h0;
  assign bus.rdata_1  = (in_resp && sel_q) ? resp_data : 32'h0;

  // Write enable is gated by reset so an interrupted RMW never lands.
  assign bus.mem_st_en   = (state == WR) && !rst_i;
  assign bus.mem_addr    = mem_phase ? {addr_q[10:2], 2'b00} : 11'h000;
  assign bus.mem_st_data = (state == WR) ? ((size_q == 2'b10) ? wdata_q : merged) : 32'h0;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: pinned literal cases, arbitration order, reset during RMW,
// then random two-port traffic checked each cycle against a transaction model.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_ctrl_if bus ();
  dmem_ctrl_if bus_fp ();

  dmem_ctrl #(.RR_EN(1'b1)) dut    (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  dmem_ctrl #(.RR_EN(1'b0)) dut_fp (.clk_i(clk), .rst_i(rst), .bus(bus_fp.slave));

  logic [31:0] dmem    [512];
  logic [31:0] ref_mem [512];
  int en_cnt = 0;

  always @(posedge clk) begin
    if (bus.mem_st_en) begin
      dmem[bus.mem_addr[10:2]] <= bus.mem_st_data;
      en_cnt <= en_cnt + 1;
    end
  end
  assign bus.mem_ld_data    = bus.mem_st_en ? 32'h0 : dmem[bus.mem_addr[10:2]];
  assign bus_fp.mem_ld_data = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input int p, input logic rq, input logic we, input logic [10:0] a,
                       input logic [1:0] sz, input logic u, input logic [31:0] wd);
    if (p == 0) begin
      bus.req_0 = rq; bus.we_0 = we; bus.addr_0 = a; bus.size_0 = sz; bus.uns_0 = u; bus.wdata_0 = wd;
    end else begin
      bus.req_1 = rq; bus.we_1 = we; bus.addr_1 = a; bus.size_1 = sz; bus.uns_1 = u; bus.wdata_1 = wd;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) bus.req_0 = 1'b0;
    else        bus.req_1 = 1'b0;
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? bus.gnt_0 : bus.gnt_1;
  endfunction
  function automatic logic rvalid_of(input int p);
    return (p == 0) ? bus.rvalid_0 : bus.rvalid_1;
  endfunction

  // One requester transaction; called at posedge+1, returns at posedge+1.
  task automatic txn(input int p, input logic we, input logic [10:0] a, input logic [1:0] sz,
                     input logic u, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat, output int gw);
    bit got;
    int t0;
    drive(p, 1'b1, we, a, sz, u, wd);
    got = 1'b0; gw = 0; rd = 32'h0; er = 1'b0; lat = -1; t0 = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (gnt_of(p)) begin got = 1'b1; t0 = cyc; end
      else gw++;
    end
    chk("gnt_wait", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    drop(p);
    if (got) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (rvalid_of(p)) begin
          got = 1'b1;
          lat = cyc - t0;
          rd  = (p == 0) ? bus.rdata_0 : bus.rdata_1;
          er  = (p == 0) ? bus.err_0 : bus.err_1;
        end
      end
      chk("rvalid_wait", {31'b0, got}, 32'd1);
      @(posedge clk); #1;
    end
  endtask

  // Transaction-level reference: what the accepted access must produce and when.
  logic        m_busy = 1'b0;
  logic        m_ptr = 1'b0;
  int          m_t, m_lat, m_port;
  logic        m_we, m_uns, m_mis;
  logic [1:0]  m_size;
  logic [10:0] m_addr;
  logic [31:0] m_wdata, m_rdata, m_wword;

  task automatic model_grant(input int p);
    logic [31:0] old, v, mask;
    int sh;
    m_port  = p;
    m_we    = (p == 0) ? bus.we_0 : bus.we_1;
    m_uns   = (p == 0) ? bus.uns_0 : bus.uns_1;
    m_size  = (p == 0) ? bus.size_0 : bus.size_1;
    m_addr  = (p == 0) ? bus.addr_0 : bus.addr_1;
    m_wdata = (p == 0) ? bus.wdata_0 : bus.wdata_1;
    m_mis   = (m_size == 2'b11) || (m_size == 2'b01 && m_addr[0]) ||
              (m_size == 2'b10 && m_addr[1:0] != 2'b00);
    old     = ref_mem[m_addr[10:2]];
    sh      = (m_size == 2'b00) ? 8 * int'(m_addr[1:0]) : 16 * int'(m_addr[1]);
    mask    = ((m_size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
    m_rdata = 32'h0;
    m_wword = 32'h0;
    if (m_mis) begin
      m_lat = 1;
    end else if (!m_we) begin
      m_lat = 2;
      if (m_size == 2'b00) begin
        v = (old >> sh) & 32'hFF;
        if (!m_uns && v[7]) v = v | 32'hFFFFFF00;
      end else if (m_size == 2'b01) begin
        v = (old >> sh) & 32'hFFFF;
        if (!m_uns && v[15]) v = v | 32'hFFFF0000;
      end else begin
        v = old;
      end
      m_rdata = v;
    end else if (m_size == 2'b10) begin
      m_lat   = 2;
      m_wword = m_wdata;
    end else begin
      m_lat   = 3;
      m_wword = (old & ~mask) | ((m_wdata << sh) & mask);
    end
    m_t    = 0;
    m_busy = 1'b1;
  endtask

  always @(negedge clk) begin : model_cmp
    logic [1:0]  e_gnt, e_rv, e_err;
    logic [31:0] e_rd0, e_rd1, e_md;
    logic        e_en;
    logic [10:0] e_ma;
    int          p;
    e_gnt = 2'b00; e_rv = 2'b00; e_err = 2'b00;
    e_rd0 = 32'h0; e_rd1 = 32'h0; e_md = 32'h0; e_en = 1'b0; e_ma = 11'h0;
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 1'b0;
    end else if (m_busy) begin
      m_t++;
      if (m_t == m_lat) begin
        e_rv[m_port]  = 1'b1;
        e_err[m_port] = m_mis;
        if (m_port == 0) e_rd0 = m_rdata;
        else             e_rd1 = m_rdata;
        m_busy = 1'b0;
      end else if (m_t == 1 && (m_lat == 3 || !m_we)) begin
        e_ma = {m_addr[10:2], 2'b00};
      end else begin
        e_en = 1'b1;
        e_ma = {m_addr[10:2], 2'b00};
        e_md = m_wword;
        ref_mem[m_addr[10:2]] = m_wword;
      end
    end else begin
      p = -1;
      if (bus.req_0 && bus.req_1) p = int'(m_ptr);
      else if (bus.req_0)         p = 0;
      else if (bus.req_1)         p = 1;
      if (p >= 0) begin
        e_gnt[p] = 1'b1;
        model_grant(p);
        m_ptr = ~m_ptr;
      end
    end
    chk("gnt",       {30'b0, bus.gnt_1, bus.gnt_0},       {30'b0, e_gnt});
    chk("rvalid",    {30'b0, bus.rvalid_1, bus.rvalid_0}, {30'b0, e_rv});
    chk("err",       {30'b0, bus.err_1, bus.err_0},       {30'b0, e_err});
    chk("rdata_0",   bus.rdata_0, e_rd0);
    chk("rdata_1",   bus.rdata_1, e_rd1);
    chk("mem_st_en", {31'b0, bus.mem_st_en}, {31'b0, e_en});
    if (!rst) begin
      chk("mem_addr",    {21'b0, bus.mem_addr}, {21'b0, e_ma});
      chk("mem_st_data", bus.mem_st_data, e_md);
    end
  end

  // Fixed-priority instance: both ports request forever, port 1 must never win.
  int fp_cnt = 0;
  always @(negedge clk) begin
    if (!rst && (bus_fp.gnt_0 || bus_fp.gnt_1)) begin
      chk("fp_gnt", {30'b0, bus_fp.gnt_1, bus_fp.gnt_0}, 32'd1);
      fp_cnt++;
    end
  end

  bit rec = 1'b0;
  int gq[$];
  always @(negedge clk) begin
    if (rec && !rst && (bus.gnt_0 || bus.gnt_1)) gq.push_back(bus.gnt_1 ? 1 : 0);
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    drop(0);
    drop(1);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    logic [31:0] rd;
    logic        er;
    int          lat, gw, r, g;
    logic [10:0] a;
    logic [1:0]  sz;
    for (int k = 0; k < n; k++) begin
      g = $urandom_range(0, 3);
      repeat (g) begin @(posedge clk); #1; end
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a  = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'b10)      a[1:0] = 2'b00;
        else if (sz == 2'b01) a[0] = 1'b0;
      end
      txn(p, 1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, rd, er, lat, gw);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got still running expected finished");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] rd;
    logic        er;
    int          lat, gw, e0;
    bit          got;

    drive(0, 1'b0, 1'b0, 11'h0, 2'b00, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 11'h0, 2'b00, 1'b0, 32'h0);
    bus_fp.req_0 = 1'b1; bus_fp.we_0 = 1'b0; bus_fp.addr_0 = 11'h0; bus_fp.size_0 = 2'b10;
    bus_fp.uns_0 = 1'b0; bus_fp.wdata_0 = 32'h0;
    bus_fp.req_1 = 1'b1; bus_fp.we_1 = 1'b0; bus_fp.addr_1 = 11'h0; bus_fp.size_1 = 2'b10;
    bus_fp.uns_1 = 1'b0; bus_fp.wdata_1 = 32'h0;

    for (int i = 0; i < 512; i++) begin
      dmem[i]    = $urandom;
      ref_mem[i] = dmem[i];
    end
    dmem[8]  = 32'h11223344; ref_mem[8]  = 32'h11223344;
    dmem[12] = 32'h8000FF80; ref_mem[12] = 32'h8000FF80;
    dmem[16] = 32'h5A5A5A5A; ref_mem[16] = 32'h5A5A5A5A;

    @(negedge clk);
    chk("rst_gnt",   {30'b0, bus.gnt_1, bus.gnt_0}, 32'd0);
    chk("rst_en",    {31'b0, bus.mem_st_en}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Word store then word load at 0x010.
    e0 = en_cnt;
    txn(0, 1'b1, 11'h010, 2'b10, 1'b0, 32'hDEADBEEF, rd, er, lat, gw);
    chk("ws_lat",    32'(lat), 32'd2);
    chk("ws_rdata",  rd, 32'h0);
    chk("ws_err",    {31'b0, er}, 32'd0);
    chk("ws_writes", 32'(en_cnt - e0), 32'd1);
    chk("ws_mem",    dmem[4], 32'hDEADBEEF);
    txn(0, 1'b0, 11'h010, 2'b10, 1'b0, 32'h0, rd, er, lat, gw);
    chk("wl_lat",    32'(lat), 32'd2);
    chk("wl_rdata",  rd, 32'hDEADBEEF);

    // Byte RMW store into 0x11223344.
    e0 = en_cnt;
    txn(0, 1'b1, 11'h022, 2'b00, 1'b0, 32'h000000AA, rd, er, lat, gw);
    chk("bs_lat",    32'(lat), 32'd3);
    chk("bs_writes", 32'(en_cnt - e0), 32'd1);
    chk("bs_mem",    dmem[8], 32'h11AA3344);

    // Sign/zero extension on 0x8000FF80.
    txn(0, 1'b0, 11'h030, 2'b00, 1'b0, 32'h0, rd, er, lat, gw);
    chk("lb_s",      rd, 32'hFFFFFF80);
    txn(1, 1'b0, 11'h031, 2'b00, 1'b1, 32'h0, rd, er, lat, gw);
    chk("lbu",       rd, 32'h000000FF);
    txn(0, 1'b0, 11'h032, 2'b01, 1'b0, 32'h0, rd, er, lat, gw);
    chk("lh_s",      rd, 32'hFFFF8000);
    chk("lh_lat",    32'(lat), 32'd2);

    // Misaligned accesses never touch memory.
    e0 = en_cnt;
    txn(0, 1'b0, 11'h013, 2'b10, 1'b0, 32'h0, rd, er, lat, gw);
    chk("mis_w_lat", 32'(lat), 32'd1);
    chk("mis_w_err", {31'b0, er}, 32'd1);
    chk("mis_w_rd",  rd, 32'h0);
    txn(1, 1'b1, 11'h041, 2'b01, 1'b0, 32'h1234, rd, er, lat, gw);
    chk("mis_h_lat", 32'(lat), 32'd1);
    chk("mis_h_err", {31'b0, er}, 32'd1);
    chk("mis_writes", 32'(en_cnt - e0), 32'd0);
    chk("mis_mem",   dmem[16], 32'h5A5A5A5A);

    // Reset lands in the RD cycle of a byte RMW.
    e0 = en_cnt;
    drive(0, 1'b1, 1'b1, 11'h020, 2'b00, 1'b0, 32'h00000055);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt_0) got = 1'b1;
    end
    chk("rrst_gnt", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    drop(0);
    @(negedge clk);
    chk("rrst_en",     {31'b0, bus.mem_st_en}, 32'd0);
    chk("rrst_rvalid", {31'b0, bus.rvalid_0}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    txn(0, 1'b0, 11'h020, 2'b10, 1'b0, 32'h0, rd, er, lat, gw);
    chk("rrst_idle",   32'(gw), 32'd0);
    chk("rrst_writes", 32'(en_cnt - e0), 32'd0);
    chk("rrst_mem",    rd, 32'h11AA3344);

    // Round-robin with both ports loading back-to-back.
    do_reset(2);
    gq.delete();
    rec = 1'b1;
    fork
      begin : rr0
        logic [31:0] r0; logic x0; int l0, g0;
        for (int k = 0; k < 4; k++) txn(0, 1'b0, 11'h030, 2'b10, 1'b0, 32'h0, r0, x0, l0, g0);
      end
      begin : rr1
        logic [31:0] r1; logic x1; int l1, g1;
        for (int k = 0; k < 4; k++) txn(1, 1'b0, 11'h034, 2'b10, 1'b0, 32'h0, r1, x1, l1, g1);
      end
    join
    rec = 1'b0;
    chk("rr_count", 32'(gq.size()), 32'd8);
    for (int i = 0; i < gq.size(); i++) chk("rr_order", 32'(gq[i]), 32'(i % 2));

    fork
      rand_port(0, 120);
      rand_port(1, 120);
    join

    chk("fp_seen", {31'b0, (fp_cnt > 20)}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with port 0 highest.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 For x in {0,1}, the block SHALL have the following requester ports.
- req_x  input  1  access request.
- we_x  input  1  1 = store, 0 = load.
- addr_x  input  11  byte address.
- size_x  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- uns_x  input  1  zero-extend load when 1.
- wdata_x  input  32  store data, right-aligned.
REQ-005 For x in {0,1}, the block SHALL have the following response ports.
- gnt_x  output  1  request accepted this cycle.
- rvalid_x  output  1  one-cycle response pulse.
- rdata_x  output  32  load result.
- err_x  output  1  misaligned or illegal access, valid with rvalid_x.
REQ-006 The block SHALL have the following memory-side ports.
- mem_st_en  output  1  word write enable.
- mem_addr  output  11  byte address, with bits [1:0] driven 00.
- mem_st_data  output  32  full word to write.
- mem_ld_data  input  32  combinational read word; reads 0 while mem_st_en = 1.

Function
REQ-007 The FSM SHALL have states IDLE, RD, WR and RESP; exactly one transaction SHALL be in flight at a time.
REQ-008 In IDLE, if any req_x = 1, exactly one gnt_x SHALL be asserted combinationally in that cycle, and that port's addr, size, we, uns and wdata SHALL be latched.
REQ-009 gnt_x SHALL be 0 in every non-IDLE state; requesters SHALL hold req_x until gnt_x.
REQ-010 With RR_EN = 1 and both requests active, the grant SHALL go to the port selected by a priority pointer. The pointer resets to 0 and moves to the other port after every grant. A single active request SHALL always be granted.
REQ-011 With RR_EN = 0 and both requests active, port 0 SHALL be granted.
REQ-012 Misaligned access SHALL mean: size = 01 with addr[0] = 1; size = 10 with addr[1:0] != 00; or size = 11.
REQ-013 Misaligned access SHALL go IDLE->RESP with err = 1 and rdata = 0; the memory SHALL NOT be accessed.
REQ-014 Load SHALL go IDLE->RD->RESP. In RD, mem_addr = {addr[10:2],00}, mem_st_en = 0, and mem_ld_data SHALL be registered.
REQ-015 Word store SHALL go IDLE->WR->RESP. In WR, mem_st_en = 1 and mem_st_data = wdata.
REQ-016 Byte or half store SHALL go IDLE->RD->WR->RESP as a read-modify-write.
- RD SHALL capture the old word.
- WR SHALL write the old word with only the addressed lane(s) replaced.
- Byte: lane addr[1:0] receives wdata[7:0].
- Half: lanes {addr[1],0} and {addr[1],1} receive wdata[15:0].
- All other bytes SHALL be unchanged.
REQ-017 Lane numbering SHALL be little-endian: lane 0 = bits [7:0].
REQ-018 Load extraction SHALL select the addressed byte/half from the registered word. It SHALL sign-extend when uns = 0 and zero-extend when uns = 1; word loads SHALL pass through unchanged.
REQ-019 RESP SHALL last one cycle.
- rvalid SHALL be asserted only on the granted port.
- rdata SHALL be 0 for stores.
- err SHALL be 0 unless misaligned.
- The next state SHALL be IDLE.
REQ-020 Latency from the gnt cycle T SHALL be:
- misaligned: rvalid at T+1;
- load and word store: rvalid at T+2;
- byte/half store: rvalid at T+3.
REQ-021 A new grant SHALL be possible no earlier than the cycle after RESP.
REQ-022 Outside RD/WR, mem_st_en, mem_addr and mem_st_data SHALL be 0.
REQ-023 rvalid_x, err_x and rdata_x SHALL be 0 outside RESP.
REQ-024 Address wrap SHALL not exist: the address is 11 bits and any value is legal subject only to alignment.

Reset
REQ-025 When rst_i is sampled high, the next state SHALL be IDLE and the priority pointer SHALL be 0.
REQ-026 While rst_i = 1:
- all gnt/rvalid/err/rdata outputs SHALL be 0;
- mem_st_en SHALL be 0, gated combinationally by rst_i so that no write occurs on any edge where rst_i = 1.
REQ-027 Reset mid-transaction SHALL drop the transaction with no rvalid; a half-finished RMW SHALL leave memory unmodified.

Verification
REQ-028 Word store port 0: addr 0x010, wdata 0xDEADBEEF -> WR at T+1 with mem_st_en = 1, rvalid_0 at T+2. A following word load of 0x010 -> rdata_0 = 0xDEADBEEF at T+2.
REQ-029 Byte store: memory word 0x11223344 at 0x020; byte store 0xAA to 0x022 -> RD at T+1, write of 0x11AA3344 at T+2, rvalid at T+3.
REQ-030 Loads from word 0x8000FF80 at 0x030:
- signed byte 0x030 -> 0xFFFFFF80;
- unsigned byte 0x031 -> 0x000000FF;
- signed half 0x032 -> 0xFFFF8000.
REQ-031 Misaligned: word load to 0x013 or half store to 0x041 -> rvalid with err = 1 at T+1, rdata = 0, mem_st_en never asserted.
REQ-032 Arbitration: both ports request loads continuously, RR_EN = 1 -> grants alternate 0,1,0,1 starting with port 0. With RR_EN = 0 -> port 0 always wins.
REQ-033 Reset mid-RMW: assert rst_i during the RD cycle of a byte store -> no mem_st_en, no rvalid, state IDLE, and the target word is unchanged on readback.
